// File: rtl/bpc_lookahead_fifo.sv
// Look-ahead output FIFO between the BPC encoder and the EBPC packer.
// The youngest word is held back until a successor or a late was_last_i tag settles its last bit.
module bpc_lookahead_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic             was_last_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("bpc_lookahead_fifo: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_last;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_tag;
    logic             w_cnt_nz;
    logic             w_cnt_one;
    logic             w_head_last;
    logic [PTR_W-1:0] w_young_ptr;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_wr_nxt;

    // Handshake, release and tagging decisions
    always_comb begin
        w_cnt_nz    = (r_count != {CNT_W{1'b0}});
        w_cnt_one   = (r_count == CNT_ONE);
        // stale last bits of already popped slots are masked by the occupancy test
        w_head_last = w_cnt_nz & r_last[r_rd_ptr];
        vld_o       = ~clr_i & ((r_count > CNT_ONE) | w_head_last |
                                (w_cnt_one & (vld_i | was_last_i)));
        last_o      = w_head_last | (w_cnt_one & was_last_i);
        w_pop       = vld_o & rdy_i;
        rdy_o       = ~clr_i & ((r_count < CNT_FULL) | w_pop);
        w_push      = vld_i & rdy_o;
        w_tag       = was_last_i & w_cnt_nz;
        w_young_ptr = (r_wr_ptr == {PTR_W{1'b0}}) ? PTR_MAX : (r_wr_ptr - PTR_ONE);
        w_rd_nxt    = (r_rd_ptr == PTR_MAX) ? {PTR_W{1'b0}} : (r_rd_ptr + PTR_ONE);
        w_wr_nxt    = (r_wr_ptr == PTR_MAX) ? {PTR_W{1'b0}} : (r_wr_ptr + PTR_ONE);
    end

    // Storage, pointers and occupancy; clear wins over every other update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= {WIDTH{1'b0}};
            end
            r_last   <= {DEPTH{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            r_last   <= {DEPTH{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            // the tag targets the pre-push youngest word; a push into the same slot overrides it
            if (w_tag) begin
                r_last[w_young_ptr] <= 1'b1;
            end
            if (w_push) begin
                r_data[r_wr_ptr] <= data_i;
                r_last[r_wr_ptr] <= last_i;
                r_wr_ptr         <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_data[r_rd_ptr];
    assign full_o  = (r_count == CNT_FULL);
    assign count_o = r_count;

    bpc_lookahead_fifo_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .was_last_i (was_last_i),
        .count_i    (r_count)
    );
endmodule

// Simulation-only observer: flags a was_last_i that has no stored word to tag.
module bpc_lookahead_fifo_chk #(
    parameter int CNT_W = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             clr_i,
    input logic             was_last_i,
    input logic [CNT_W-1:0] count_i
);
    // Report an ignored tag on an empty buffer
    always @(posedge clk_i) begin
        if (rst_ni && !clr_i && was_last_i && (count_i == {CNT_W{1'b0}})) begin
            $warning("bpc_lookahead_fifo: was_last_i on empty buffer ignored");
        end
    end
endmodule

// File: tb/tb_bpc_lookahead_fifo.sv
// Scoreboard bench for bpc_lookahead_fifo at DEPTH 1, 3 and 4: directed scenarios, then a random run against a queue model.
module tb_bpc_lookahead_fifo;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       clr   [3];
    logic [7:0] din   [3];
    logic       lin   [3];
    logic       vin   [3];
    logic       wl    [3];
    logic       rdy_i [3];
    logic [7:0] dout  [3];
    logic       lout  [3];
    logic       vout  [3];
    logic       rdy_o [3];
    logic       full  [3];
    logic [2:0] cnt   [3];
    logic [0:0] cnt1;
    logic [1:0] cnt3;
    logic [2:0] cnt4;

    assign cnt[0] = {2'b00, cnt1};
    assign cnt[1] = {1'b0, cnt3};
    assign cnt[2] = cnt4;

    bpc_lookahead_fifo #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .data_i(din[0]), .last_i(lin[0]),
        .vld_i(vin[0]), .rdy_o(rdy_o[0]), .was_last_i(wl[0]), .data_o(dout[0]),
        .last_o(lout[0]), .vld_o(vout[0]), .rdy_i(rdy_i[0]), .full_o(full[0]), .count_o(cnt1));
    bpc_lookahead_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .data_i(din[1]), .last_i(lin[1]),
        .vld_i(vin[1]), .rdy_o(rdy_o[1]), .was_last_i(wl[1]), .data_o(dout[1]),
        .last_o(lout[1]), .vld_o(vout[1]), .rdy_i(rdy_i[1]), .full_o(full[1]), .count_o(cnt3));
    bpc_lookahead_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .data_i(din[2]), .last_i(lin[2]),
        .vld_i(vin[2]), .rdy_o(rdy_o[2]), .was_last_i(wl[2]), .data_o(dout[2]),
        .last_o(lout[2]), .vld_o(vout[2]), .rdy_i(rdy_i[2]), .full_o(full[2]), .count_o(cnt4));

    logic [8:0] exp_q [3][$];
    logic       model_on;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l, input logic w);
        vin[k] = v;
        din[k] = d;
        lin[k] = l;
        wl[k]  = w;
    endtask

    task automatic exp_out(input int k, input logic [7:0] d, input logic l);
        exp_q[k].push_back({d, l});
    endtask

    int         m_dep;
    int         m_sz;
    logic       m_pop;
    logic       m_push;
    logic       m_rel;
    logic [8:0] m_ent;
    logic [8:0] m_head;

    // Monitor: checks each popped word; in model mode it also tracks contents, tags and flags
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_dep  = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
                m_sz   = exp_q[k].size();
                m_pop  = vout[k] & rdy_i[k];
                m_push = vin[k] & rdy_o[k];
                if (clr[k]) begin
                    exp_q[k].delete();
                end else begin
                    if (model_on) begin
                        m_head = (m_sz > 0) ? exp_q[k][0] : 9'h000;
                        m_rel  = (m_sz >= 2) || ((m_sz > 0) && m_head[0]) ||
                                 ((m_sz == 1) && (vin[k] || wl[k]));
                        check($sformatf("vld_o_d%0d", m_dep), int'(vout[k]), int'(m_rel));
                        check($sformatf("count_o_d%0d", m_dep), int'(cnt[k]), m_sz);
                        check($sformatf("count_le_depth_d%0d", m_dep), int'(int'(cnt[k]) <= m_dep), 1);
                        check($sformatf("rdy_o_d%0d", m_dep), int'(rdy_o[k]),
                              int'((m_sz < m_dep) || m_pop));
                        if (wl[k] && (m_sz > 0)) begin
                            m_ent    = exp_q[k][m_sz-1];
                            m_ent[0] = 1'b1;
                            exp_q[k][m_sz-1] = m_ent;
                        end
                    end
                    if (m_pop) begin
                        if (exp_q[k].size() == 0) begin
                            n_chk++;
                            $display("FAIL pop_d%0d: unexpected word 0x%0h last %0d, required none",
                                     m_dep, dout[k], lout[k]);
                        end else begin
                            m_ent = exp_q[k].pop_front();
                            check($sformatf("pop_d%0d", m_dep), int'({dout[k], lout[k]}), int'(m_ent));
                        end
                    end
                    if (model_on && m_push) exp_q[k].push_back({din[k], lin[k]});
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        model_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr[k]   = 1'b0;
            rdy_i[k] = 1'b1;
            drive(k, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_vld_%0d", k), int'(vout[k]), 0);
            check($sformatf("rst_last_%0d", k), int'(lout[k]), 0);
            check($sformatf("rst_rdy_%0d", k), int'(rdy_o[k]), 1);
            check($sformatf("rst_full_%0d", k), int'(full[k]), 0);
            check($sformatf("rst_cnt_%0d", k), int'(cnt[k]), 0);
            check($sformatf("rst_data_%0d", k), int'(dout[k]), 0);
        end
        rst_n = 1'b1;
        tick;

        // DEPTH=1: A released by B's arrival, B released by a late tag
        drive(0, 1'b1, 8'hA1, 1'b0, 1'b0); tick;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t1_hold_vld", int'(vout[0]), 0);
        check("t1_cnt1", int'(cnt[0]), 1);
        check("t1_full", int'(full[0]), 1);
        drive(0, 1'b1, 8'hB2, 1'b0, 1'b0); exp_out(0, 8'hA1, 1'b0); #1;
        check("t1_rdy_via_pop", int'(rdy_o[0]), 1);
        tick;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1); exp_out(0, 8'hB2, 1'b1); #1;
        check("t1_tag_last", int'(lout[0]), 1);
        tick;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t1_cnt0", int'(cnt[0]), 0);
        check("t1_vld0", int'(vout[0]), 0);

        // DEPTH=4 stalled until full, then simultaneous push and pop
        rdy_i[2] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(2, 1'b1, 8'(i), 1'b0, 1'b0); tick;
        end
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t2_full", int'(full[2]), 1);
        check("t2_rdy0", int'(rdy_o[2]), 0);
        check("t2_vld1", int'(vout[2]), 1);
        check("t2_cnt4", int'(cnt[2]), 4);
        rdy_i[2] = 1'b1;
        drive(2, 1'b1, 8'h05, 1'b0, 1'b0); exp_out(2, 8'h01, 1'b0); #1;
        check("t2_rdy_full_pop", int'(rdy_o[2]), 1);
        tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); exp_out(2, 8'h02, 1'b0); #1;
        check("t2_cnt_stays4", int'(cnt[2]), 4);
        tick;
        exp_out(2, 8'h03, 1'b0); tick;
        exp_out(2, 8'h04, 1'b0); tick;
        #1;
        check("t2_last_held", int'(vout[2]), 0);
        check("t2_cnt1", int'(cnt[2]), 1);
        drive(2, 1'b0, 8'h00, 1'b0, 1'b1); exp_out(2, 8'h05, 1'b1); tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t2_cnt0", int'(cnt[2]), 0);

        // DEPTH=3: tag coinciding with a push marks the older word
        drive(1, 1'b1, 8'h01, 1'b0, 1'b0); tick;
        drive(1, 1'b1, 8'h02, 1'b0, 1'b0); exp_out(1, 8'h01, 1'b0); tick;
        drive(1, 1'b1, 8'h03, 1'b0, 1'b1); exp_out(1, 8'h02, 1'b1); #1;
        check("t3_tag_last", int'(lout[1]), 1);
        tick;
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t3_hold3", int'(vout[1]), 0);
        check("t3_cnt1", int'(cnt[1]), 1);
        check("t3_head3", int'(dout[1]), 3);
        drive(1, 1'b1, 8'h04, 1'b0, 1'b0); exp_out(1, 8'h03, 1'b0); tick;
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1); exp_out(1, 8'h04, 1'b1); tick;
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t3_cnt0", int'(cnt[1]), 0);

        // Word pushed with last_i=1 needs no successor
        rdy_i[1] = 1'b0;
        drive(1, 1'b1, 8'h5A, 1'b1, 1'b0); tick;
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t4_vld", int'(vout[1]), 1);
        check("t4_last", int'(lout[1]), 1);
        check("t4_data", int'(dout[1]), 8'h5A);
        rdy_i[1] = 1'b1; exp_out(1, 8'h5A, 1'b1); tick;
        #1;
        check("t4_cnt0", int'(cnt[1]), 0);

        // Tag on empty buffer is ignored; clear discards content and resets pointers
        drive(2, 1'b0, 8'h00, 1'b0, 1'b1); #1;
        check("t5_empty_tag_vld", int'(vout[2]), 0);
        tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t5_empty_tag_cnt", int'(cnt[2]), 0);
        check("t5_empty_tag_last", int'(lout[2]), 0);
        rdy_i[2] = 1'b0;
        drive(2, 1'b1, 8'h11, 1'b0, 1'b0); tick;
        drive(2, 1'b1, 8'h22, 1'b0, 1'b0); tick;
        drive(2, 1'b1, 8'h33, 1'b0, 1'b0); tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t5_cnt3", int'(cnt[2]), 3);
        clr[2] = 1'b1; #1;
        check("t5_clr_vld", int'(vout[2]), 0);
        check("t5_clr_rdy", int'(rdy_o[2]), 0);
        tick;
        clr[2] = 1'b0; #1;
        check("t5_clr_cnt", int'(cnt[2]), 0);
        check("t5_clr_vld_after", int'(vout[2]), 0);
        rdy_i[2] = 1'b1;
        drive(2, 1'b1, 8'h77, 1'b0, 1'b0); tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t5_head_after_clr", int'(dout[2]), 8'h77);
        drive(2, 1'b0, 8'h00, 1'b0, 1'b1); exp_out(2, 8'h77, 1'b1); tick;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0); #1;
        check("t5_cnt0", int'(cnt[2]), 0);

        // Random traffic on all depths against the queue model
        model_on = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 3; k++) begin
                vin[k]   = ($urandom_range(0, 99) < 60);
                din[k]   = 8'($urandom);
                lin[k]   = ($urandom_range(0, 99) < 10);
                wl[k]    = (exp_q[k].size() > 0) && ($urandom_range(0, 99) < 15);
                rdy_i[k] = ($urandom_range(0, 99) < 70);
            end
            tick;
        end
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 3; k++) begin
                drive(k, 1'b0, 8'h00, 1'b0, exp_q[k].size() > 0);
                rdy_i[k] = 1'b1;
            end
            tick;
        end
        model_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 8'h00, 1'b0, 1'b0);
            check($sformatf("drain_cnt_%0d", k), int'(cnt[k]), 0);
            check($sformatf("drain_queue_%0d", k), exp_q[k].size(), 0);
        end
        tick;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
